median_window_feeder: RTL

//   Upstream stage of the 3-input median finder. Takes a framed stream of

---
 rtl/median_window_feeder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/median_window_feeder.sv
// 3-deep sliding window feeder for the median finder; latency 1 (registered window).
// in_ready drops while the output register is stalled or a padding window is pending.
// Optional edge padding via MEDIAN_EDGE_PAD_EN.
module median_window_feeder #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] num1,
  output logic [DATA_W-1:0] num2,
  output logic [DATA_W-1:0] num3,
  output logic              out_last,
  output logic              short_err
);

  typedef enum logic [1:0] {IDLE, HAVE1, STREAM, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] h_old, h_new, h_old_nxt, h_new_nxt;
  logic [DATA_W-1:0] w1, w2, w3;
  logic              w_last, w_load, short_nxt;
  logic              room, acc;

  // One-entry output register: a new window may load whenever the current one leaves.
  assign room     = !out_valid || out_ready;
  assign in_ready = (state != FLUSH) && room;
  assign acc      = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    h_old_nxt = h_old;
    h_new_nxt = h_new;
    w1        = h_old;
    w2        = h_new;
    w3        = in_data;
    w_last    = 1'b0;
    w_load    = 1'b0;
    short_nxt = 1'b0;
    case (state)
      IDLE: if (acc) begin
        h_new_nxt = in_data;
        if (in_last) begin
`ifdef MEDIAN_EDGE_PAD_EN
          w1     = in_data;
          w2     = in_data;
          w_load = 1'b1;
          w_last = 1'b1;
`else
          short_nxt = 1'b1;
`endif
        end else begin
          state_nxt = HAVE1;
        end
      end
      HAVE1: if (acc) begin
        h_old_nxt = h_new;
        h_new_nxt = in_data;
`ifdef MEDIAN_EDGE_PAD_EN
        // Leading edge replicates s0 into the oldest slot.
        w1        = h_new;
        w2        = h_new;
        w_load    = 1'b1;
        state_nxt = in_last ? FLUSH : STREAM;
`else
        if (in_last) begin
          short_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = STREAM;
        end
`endif
      end
      STREAM: if (acc) begin
        h_old_nxt = h_new;
        h_new_nxt = in_data;
        w_load    = 1'b1;
        if (in_last) begin
`ifdef MEDIAN_EDGE_PAD_EN
          state_nxt = FLUSH;
`else
          w_last    = 1'b1;
          state_nxt = IDLE;
`endif
        end
      end
      FLUSH: begin
        // Trailing edge replicates the final sample into the newest slot.
        w1     = h_old;
        w2     = h_new;
        w3     = h_new;
        w_last = 1'b1;
        if (room) begin
          w_load    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      h_old     <= '0;
      h_new     <= '0;
      out_valid <= 1'b0;
      num1      <= '0;
      num2      <= '0;
      num3      <= '0;
      out_last  <= 1'b0;
      short_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      h_old     <= h_old_nxt;
      h_new     <= h_new_nxt;
      short_err <= short_nxt;
      if (w_load) begin
        out_valid <= 1'b1;
        num1      <= w1;
        num2      <= w2;
        num3      <= w3;
        out_last  <= w_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
